fwft_read_adapter: RTL

Read-side adapter that turns a standard-mode FIFO read port (data one cycle after `rd_en`) into a first-word-fall-through (FWFT) port. It sits between the `standard_fifo` read interface and any consumer that expects the head word to be already on `fwft_dout` whenever `fwft_valid` is high. It prefetches words into an internal output register plus an optional skid register. With the skid register it sustains one word per clock.

---
 rtl/fwft_read_adapter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fwft_read_adapter.sv
// fwft_read_adapter
//
// Converts a standard-mode FIFO read port, where data arrives one cycle after the
// read strobe, into a first-word-fall-through port. The head word is registered on
// fwft_dout whenever fwft_valid is high. Words are prefetched into a head register,
// plus an optional skid register.
//
// Build option:
//   FWFT_SKID_EN - when defined, adds the skid register. Capacity becomes 2 words and
//                  the adapter sustains one word per clock. When undefined, capacity is
//                  1 word and throughput is one word per two clocks.
//
// Ports:
//   clk          in   clock, rising-edge
//   reset_n      in   asynchronous active-low reset
//   fifo_dout    in   standard FIFO read data (valid the cycle after fifo_rd_en)
//   fifo_empty   in   standard FIFO empty flag
//   fifo_rd_en   out  read strobe to the standard FIFO (combinational)
//   fwft_rd_en   in   consumer pop; ignored while fwft_valid is low
//   fwft_dout    out  head word (registered)
//   fwft_valid   out  head word present (registered)
//   fwft_empty   out  inverse of fwft_valid

module fwft_read_adapter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  fwft_rd_en,
  output logic [DATA_WIDTH-1:0] fwft_dout,
  output logic                  fwft_valid,
  output logic                  fwft_empty
);

  logic                  r_in_flight;
  logic                  r_head_vld;
  logic [DATA_WIDTH-1:0] r_head;
  logic                  w_head_vld_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic                  w_pop;
  logic                  w_room;

`ifdef FWFT_SKID_EN
  logic                  r_skid_vld;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  w_skid_vld_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic [1:0]            w_used;
`endif

  assign w_pop = fwft_rd_en & r_head_vld;

`ifdef FWFT_SKID_EN
  // Held words plus the word already requested from the FIFO.
  assign w_used = {1'b0, r_head_vld} + {1'b0, r_skid_vld} + {1'b0, r_in_flight};
  // A pop in the same cycle frees a slot for the word this read returns.
  assign w_room = (w_used < 2'd2) | ((w_used == 2'd2) & w_pop);
`else
  // Single slot: refill only when it is empty, or when the held word leaves now
  // and nothing else is already on its way.
  assign w_room = (~r_head_vld & ~r_in_flight) | (r_head_vld & ~r_in_flight & w_pop);
`endif

  assign fifo_rd_en = reset_n & ~fifo_empty & w_room;

  always_comb begin
    w_head_nxt     = r_head;
    w_head_vld_nxt = r_head_vld;
`ifdef FWFT_SKID_EN
    w_skid_nxt     = r_skid;
    w_skid_vld_nxt = r_skid_vld;
`endif
    if (w_pop) begin
`ifdef FWFT_SKID_EN
      if (r_skid_vld) begin
        // Skid word advances; an arriving word refills the skid.
        w_head_nxt     = r_skid;
        w_skid_vld_nxt = r_in_flight;
        if (r_in_flight) begin
          w_skid_nxt = fifo_dout;
        end
      end else
`endif
      begin
        // Head empties after the pop, so an arriving word lands straight in head.
        w_head_vld_nxt = r_in_flight;
        if (r_in_flight) begin
          w_head_nxt = fifo_dout;
        end
      end
    end else if (r_in_flight) begin
`ifdef FWFT_SKID_EN
      if (r_head_vld) begin
        w_skid_nxt     = fifo_dout;
        w_skid_vld_nxt = 1'b1;
      end else
`endif
      begin
        w_head_nxt     = fifo_dout;
        w_head_vld_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_flight <= 1'b0;
      r_head_vld  <= 1'b0;
      r_head      <= '0;
`ifdef FWFT_SKID_EN
      r_skid_vld  <= 1'b0;
      r_skid      <= '0;
`endif
    end else begin
      r_in_flight <= fifo_rd_en;
      r_head_vld  <= w_head_vld_nxt;
      r_head      <= w_head_nxt;
`ifdef FWFT_SKID_EN
      r_skid_vld  <= w_skid_vld_nxt;
      r_skid      <= w_skid_nxt;
`endif
    end
  end

  assign fwft_dout  = r_head;
  assign fwft_valid = r_head_vld;
  assign fwft_empty = ~r_head_vld;

endmodule
